// File: rtl/hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard/flush controller.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        HC_RUN         = 2'd0,
        HC_FLUSH_FRONT = 2'd1,
        HC_FLUSH_ALL   = 2'd2
    } hc_state_e;

    localparam int HC_DEPTH        = 4;
    localparam int HC_FLUSH_CYCLES = 1;
    localparam int HC_RA_W         = 5;

endpackage

// File: rtl/hazard_ctrl_inflight_queue.sv
// In-order queue of issued instructions tagged {has_rd, rd}; lookups, occupancy, sticky retire-error flag.
module inflight_queue
    import hazard_ctrl_pkg::*;
#(
    parameter int DEPTH = HC_DEPTH,
    parameter int RA_W  = HC_RA_W,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push_i,
    input  logic            push_has_rd_i,
    input  logic [RA_W-1:0] push_rd_i,
    input  logic            pop_i,
    input  logic            clear_i,
    input  logic            ret_has_rd_i,
    input  logic [RA_W-1:0] ret_rd_i,
    input  logic [RA_W-1:0] lk1_addr_i,
    input  logic [RA_W-1:0] lk2_addr_i,
    output logic            lk1_hit_o,
    output logic            lk2_hit_o,
    output logic [CW-1:0]   count_o,
    output logic            err_o
);

    logic [RA_W-1:0] rd_q [DEPTH];
    logic [DEPTH-1:0] has_q;
    logic [DEPTH-1:0] vld_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             err_q;
    logic             empty;
    logic             do_pop;
    logic             mismatch;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty    = (count_q == '0);
    assign do_pop   = pop_i && !empty;
    // Tag disagreement alone is an error; the address only matters when a write was tracked.
    assign mismatch = (has_q[rd_ptr_q] != ret_has_rd_i) ||
                      (has_q[rd_ptr_q] && (rd_q[rd_ptr_q] != ret_rd_i));

    always_comb begin
        lk1_hit_o = 1'b0;
        lk2_hit_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && has_q[i] && (rd_q[i] == lk1_addr_i)) lk1_hit_o = 1'b1;
            if (vld_q[i] && has_q[i] && (rd_q[i] == lk2_addr_i)) lk2_hit_o = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '0;
            has_q    <= '0;
            err_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) rd_q[i] <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '0;
        end else begin
            if (pop_i && (empty || mismatch)) err_q <= 1'b1;
            if (do_pop) begin
                vld_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q        <= ptr_next(rd_ptr_q);
            end
            // Placed after the pop so a full-queue push into the slot being freed wins.
            if (push_i) begin
                vld_q[wr_ptr_q] <= 1'b1;
                has_q[wr_ptr_q] <= push_has_rd_i;
                rd_q[wr_ptr_q]  <= push_rd_i;
                wr_ptr_q        <= ptr_next(wr_ptr_q);
            end
            case ({push_i, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign count_o = count_q;
    assign err_o   = err_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush controller: RAW hazard stalls from the in-flight queue, registered flush sequencing.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int DEPTH        = HC_DEPTH,
    parameter int FLUSH_CYCLES = HC_FLUSH_CYCLES,
    parameter int RA_W         = HC_RA_W,
    localparam int CW          = $clog2(DEPTH + 1),
    localparam int FW          = $clog2(FLUSH_CYCLES + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            dec_valid,
    input  logic [RA_W-1:0] dec_rs1_addr,
    input  logic            dec_rs1_used,
    input  logic [RA_W-1:0] dec_rs2_addr,
    input  logic            dec_rs2_used,
    input  logic [RA_W-1:0] dec_rd_addr,
    input  logic            dec_rd_wr,
    input  logic            wb_valid,
    input  logic [RA_W-1:0] wb_rd_addr,
    input  logic            wb_rd_wr,
    input  logic            ex_redirect,
    input  logic            wb_exception,
    output logic            stall_fetch,
    output logic            stall_decode,
    output logic            flush_fetch,
    output logic            flush_decode,
    output logic            flush_execute,
    output logic [CW-1:0]   sb_count,
    output logic            sb_error
);

    hc_state_e     state_q, state_d;
    logic [FW-1:0] cnt_q, cnt_d;
    logic          hit1, hit2;
    logic          haz, full, run, stall, issue, pop;

    assign run   = (state_q == HC_RUN);
    assign haz   = dec_valid && ((dec_rs1_used && (dec_rs1_addr != '0) && hit1) ||
                                 (dec_rs2_used && (dec_rs2_addr != '0) && hit2));
    assign full  = (sb_count == CW'(DEPTH)) && !wb_valid;
    assign stall = (haz || (dec_valid && full)) && run;
    assign issue = dec_valid && !stall && run && !ex_redirect && !wb_exception;
    // Retires are dropped while the whole pipe is being squashed, including the entry edge.
    assign pop   = wb_valid && !wb_exception && (state_q != HC_FLUSH_ALL);

    assign stall_fetch  = stall;
    assign stall_decode = stall;

    inflight_queue #(
        .DEPTH (DEPTH),
        .RA_W  (RA_W)
    ) u_queue (
        .clk           (clk),
        .reset         (reset),
        .push_i        (issue),
        .push_has_rd_i (dec_rd_wr && (dec_rd_addr != '0)),
        .push_rd_i     (dec_rd_addr),
        .pop_i         (pop),
        .clear_i       (wb_exception),
        .ret_has_rd_i  (wb_rd_wr && (wb_rd_addr != '0)),
        .ret_rd_i      (wb_rd_addr),
        .lk1_addr_i    (dec_rs1_addr),
        .lk2_addr_i    (dec_rs2_addr),
        .lk1_hit_o     (hit1),
        .lk2_hit_o     (hit2),
        .count_o       (sb_count),
        .err_o         (sb_error)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= HC_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        flush_fetch   = 1'b0;
        flush_decode  = 1'b0;
        flush_execute = 1'b0;
        case (state_q)
            HC_FLUSH_FRONT: begin
                flush_fetch  = 1'b1;
                flush_decode = 1'b1;
            end
            HC_FLUSH_ALL: begin
                flush_fetch   = 1'b1;
                flush_decode  = 1'b1;
                flush_execute = 1'b1;
            end
            default: ;
        endcase
        if (wb_exception) begin
            state_d = HC_FLUSH_ALL;
            cnt_d   = FW'(FLUSH_CYCLES);
        end else if (run) begin
            if (ex_redirect) begin
                state_d = HC_FLUSH_FRONT;
                cnt_d   = FW'(FLUSH_CYCLES);
            end
        end else if (cnt_q <= FW'(1)) begin
            state_d = HC_RUN;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q - FW'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench: directed literal checks plus randomized traffic against a queue-based reference model.
module tb_hazard_ctrl;

    localparam int DEPTH = 4;
    localparam int FC    = 1;
    localparam int RA_W  = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            dec_valid, dec_rs1_used, dec_rs2_used, dec_rd_wr;
    logic [RA_W-1:0] dec_rs1_addr, dec_rs2_addr, dec_rd_addr;
    logic            wb_valid, wb_rd_wr, ex_redirect, wb_exception;
    logic [RA_W-1:0] wb_rd_addr;
    logic            stall_fetch, stall_decode, flush_fetch, flush_decode, flush_execute;
    logic [2:0]      sb_count;
    logic            sb_error;

    int total = 0;
    int bad   = 0;

    hazard_ctrl #(.DEPTH(DEPTH), .FLUSH_CYCLES(FC), .RA_W(RA_W)) dut (
        .clk(clk), .reset(reset),
        .dec_valid(dec_valid), .dec_rs1_addr(dec_rs1_addr), .dec_rs1_used(dec_rs1_used),
        .dec_rs2_addr(dec_rs2_addr), .dec_rs2_used(dec_rs2_used),
        .dec_rd_addr(dec_rd_addr), .dec_rd_wr(dec_rd_wr),
        .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr), .wb_rd_wr(wb_rd_wr),
        .ex_redirect(ex_redirect), .wb_exception(wb_exception),
        .stall_fetch(stall_fetch), .stall_decode(stall_decode),
        .flush_fetch(flush_fetch), .flush_decode(flush_decode), .flush_execute(flush_execute),
        .sb_count(sb_count), .sb_error(sb_error)
    );

    always #5 clk = ~clk;

    // Reference model: in-flight list, mode (0 run, 1 front flush, 2 full flush), hold count, error.
    typedef struct {
        bit       has;
        bit [4:0] rd;
    } ent_t;
    ent_t mq[$];
    int   m_mode = 0;
    int   m_cnt  = 0;
    bit   m_err  = 0;

    function automatic bit m_stall();
        bit haz = 0;
        bit full;
        foreach (mq[i]) begin
            if (mq[i].has && dec_rs1_used && dec_rs1_addr != 0 && mq[i].rd == dec_rs1_addr) haz = 1;
            if (mq[i].has && dec_rs2_used && dec_rs2_addr != 0 && mq[i].rd == dec_rs2_addr) haz = 1;
        end
        full = (mq.size() == DEPTH) && !wb_valid;
        return ((dec_valid && haz) || (dec_valid && full)) && (m_mode == 0);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_mode = 0;
            m_cnt  = 0;
            m_err  = 0;
        end else begin
            bit   iss;
            ent_t e;
            iss = dec_valid && !m_stall() && m_mode == 0 && !ex_redirect && !wb_exception;
            if (wb_exception) begin
                mq.delete();
                m_mode = 2;
                m_cnt  = FC;
            end else begin
                if (wb_valid && m_mode != 2) begin
                    if (mq.size() == 0) m_err = 1;
                    else begin
                        e = mq.pop_front();
                        if (e.has != (wb_rd_wr && wb_rd_addr != 0) || (e.has && e.rd != wb_rd_addr))
                            m_err = 1;
                    end
                end
                if (iss) begin
                    e.has = dec_rd_wr && dec_rd_addr != 0;
                    e.rd  = dec_rd_addr;
                    mq.push_back(e);
                end
                if (m_mode == 0) begin
                    if (ex_redirect) begin
                        m_mode = 1;
                        m_cnt  = FC;
                    end
                end else if (m_cnt == 1) m_mode = 0;
                else m_cnt--;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        #1;
        chk("m_stall_fetch",   32'(stall_fetch),   32'(m_stall()));
        chk("m_stall_decode",  32'(stall_decode),  32'(m_stall()));
        chk("m_flush_fetch",   32'(flush_fetch),   32'(m_mode != 0));
        chk("m_flush_decode",  32'(flush_decode),  32'(m_mode != 0));
        chk("m_flush_execute", 32'(flush_execute), 32'(m_mode == 2));
        chk("m_sb_count",      32'(sb_count),      32'(mq.size()));
        chk("m_sb_error",      32'(sb_error),      32'(m_err));
    end

    task automatic idle();
        dec_valid = 0; dec_rs1_addr = 0; dec_rs1_used = 0; dec_rs2_addr = 0; dec_rs2_used = 0;
        dec_rd_addr = 0; dec_rd_wr = 0; wb_valid = 0; wb_rd_addr = 0; wb_rd_wr = 0;
        ex_redirect = 0; wb_exception = 0;
    endtask

    task automatic issue_rd(input int rd);
        @(negedge clk); idle();
        dec_valid = 1; dec_rd_addr = 5'(rd); dec_rd_wr = 1;
    endtask

    task automatic pulse_reset();
        @(negedge clk); idle(); reset = 1;
        @(negedge clk); reset = 0;
    endtask

    initial begin
        reset = 1;
        idle();
        @(negedge clk); #1;
        chk("rst_count", 32'(sb_count), 0);
        chk("rst_stall", 32'(stall_decode), 0);
        chk("rst_flush", 32'(flush_fetch | flush_decode | flush_execute), 0);
        chk("rst_error", 32'(sb_error), 0);
        @(negedge clk); reset = 0;

        // RAW stall on x5 held through the retire cycle, released the cycle after
        issue_rd(5);
        @(negedge clk); idle(); dec_valid = 1; dec_rs1_addr = 5; dec_rs1_used = 1; #1;
        chk("raw_stall", 32'(stall_fetch), 1);
        chk("raw_count", 32'(sb_count), 1);
        @(negedge clk); wb_valid = 1; wb_rd_addr = 5; wb_rd_wr = 1; #1;
        chk("raw_stall_retire_cycle", 32'(stall_decode), 1);
        @(negedge clk); wb_valid = 0; #1;
        chk("raw_stall_released", 32'(stall_decode), 0);
        chk("raw_count_zero", 32'(sb_count), 0);
        @(negedge clk); idle(); wb_valid = 1;

        // Fill to DEPTH, then full stall relieved by a same-cycle retire
        issue_rd(1); issue_rd(2); issue_rd(3); issue_rd(4);
        issue_rd(9); #1;
        chk("full_count", 32'(sb_count), 4);
        chk("full_stall", 32'(stall_fetch), 1);
        @(negedge clk); wb_valid = 1; wb_rd_addr = 1; wb_rd_wr = 1; #1;
        chk("full_retire_no_stall", 32'(stall_fetch), 0);
        @(negedge clk); idle(); #1;
        chk("full_count_kept", 32'(sb_count), 4);

        // Redirect: same-cycle decode dropped, front flush for FC cycles, retires continue
        @(negedge clk); idle(); dec_valid = 1; dec_rd_addr = 10; dec_rd_wr = 1; ex_redirect = 1;
        wb_valid = 1; wb_rd_addr = 2; wb_rd_wr = 1;
        @(negedge clk); idle(); wb_valid = 1; wb_rd_addr = 3; wb_rd_wr = 1; #1;
        chk("redir_flush_fetch", 32'(flush_fetch), 1);
        chk("redir_flush_decode", 32'(flush_decode), 1);
        chk("redir_flush_execute", 32'(flush_execute), 0);
        chk("redir_count", 32'(sb_count), 3);
        @(negedge clk); idle(); #1;
        chk("redir_flush_done", 32'(flush_fetch), 0);
        chk("redir_count_after", 32'(sb_count), 2);
        chk("redir_no_error", 32'(sb_error), 0);

        // Exception clears the queue and flushes all stages
        issue_rd(11);
        @(negedge clk); idle(); dec_valid = 1; dec_rd_addr = 12; dec_rd_wr = 1;
        wb_exception = 1; ex_redirect = 1; wb_valid = 1; wb_rd_addr = 4; wb_rd_wr = 1; #1;
        chk("exc_count_before", 32'(sb_count), 3);
        @(negedge clk); idle(); #1;
        chk("exc_count_cleared", 32'(sb_count), 0);
        chk("exc_flush_all", 32'({flush_fetch, flush_decode, flush_execute}), 7);
        @(negedge clk); idle(); #1;
        chk("exc_flush_done", 32'(flush_execute), 0);

        // Retire address mismatch, then retire on empty queue
        issue_rd(6);
        @(negedge clk); idle(); wb_valid = 1; wb_rd_addr = 7; wb_rd_wr = 1;
        @(negedge clk); idle(); #1;
        chk("mismatch_error", 32'(sb_error), 1);
        @(negedge clk); #1;
        chk("mismatch_sticky", 32'(sb_error), 1);
        pulse_reset();
        @(negedge clk); idle(); wb_valid = 1; #1;
        chk("empty_err_before", 32'(sb_error), 0);
        @(negedge clk); idle(); #1;
        chk("empty_error", 32'(sb_error), 1);
        chk("empty_count", 32'(sb_count), 0);
        pulse_reset();

        // x0 destination tracks no write; reading x0 never stalls
        issue_rd(0);
        @(negedge clk); idle(); dec_valid = 1; dec_rs1_used = 1; dec_rs2_used = 1; #1;
        chk("x0_no_stall", 32'(stall_decode), 0);
        chk("x0_count", 32'(sb_count), 1);
        @(negedge clk); idle(); wb_valid = 1; wb_rd_wr = 1;
        @(negedge clk); idle(); wb_valid = 1;
        @(negedge clk); idle(); #1;
        chk("x0_count_zero", 32'(sb_count), 0);
        chk("x0_no_error", 32'(sb_error), 0);

        // Reset in the middle of a full flush
        @(negedge clk); idle(); wb_exception = 1;
        @(negedge clk); idle(); #1;
        chk("mid_flush_active", 32'(flush_execute), 1);
        #2 reset = 1; #1;
        chk("mid_flush_reset", 32'({flush_fetch, flush_decode, flush_execute}), 0);
        @(negedge clk); reset = 0;

        // Randomized traffic with well-formed retires
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            idle();
            if (n == 1500) reset = 1;
            else reset = 0;
            dec_valid    = ($urandom % 4) != 0;
            dec_rs1_addr = 5'($urandom % 8);
            dec_rs1_used = $urandom % 2;
            dec_rs2_addr = 5'($urandom % 8);
            dec_rs2_used = $urandom % 2;
            dec_rd_addr  = 5'($urandom % 8);
            dec_rd_wr    = ($urandom % 4) != 0;
            if (mq.size() > 0 && ($urandom % 3) == 0) begin
                wb_valid   = 1;
                wb_rd_wr   = mq[0].has;
                wb_rd_addr = mq[0].has ? mq[0].rd : 5'd0;
            end
            ex_redirect  = ($urandom % 16) == 0;
            wb_exception = ($urandom % 50) == 0;
        end
        @(negedge clk); idle();
        @(negedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline control unit for the in-order core; owns the stall and flush lines that the fetch, decode and execute stages sample.
- Keeps an in-order scoreboard of instructions issued from decode to execute that have not yet written back.
- Detects read-after-write hazards on the decode source registers and stalls fetch and decode until the producer retires.
- Sequences flushes on an execute redirect (branch or jump) and on a writeback exception, including a flush hold counter.

Parameters:
- DEPTH, 4: maximum in-flight destination entries between execute and writeback. Must be ≥ 2.
- FLUSH_CYCLES, 1: number of cycles each flush is held asserted. Must be ≥ 1.
- RA_W, 5: register address width. Equals `REG_ADDR_SIZE+1 from def_params.v.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- dec_valid  in  1  decode holds a valid instruction this cycle
- dec_rs1_addr  in  RA_W  decode source register 1
- dec_rs1_used  in  1  instruction reads rs1
- dec_rs2_addr  in  RA_W  decode source register 2
- dec_rs2_used  in  1  instruction reads rs2
- dec_rd_addr  in  RA_W  decode destination register
- dec_rd_wr  in  1  instruction writes rd
- wb_valid  in  1  writeback retires an instruction this cycle
- wb_rd_addr  in  RA_W  retiring destination register
- wb_rd_wr  in  1  retiring instruction wrote rd
- ex_redirect  in  1  execute resolved a taken branch or jump
- wb_exception  in  1  writeback raised an exception
- stall_fetch  out  1  hold fetch
- stall_decode  out  1  hold decode; no issue into execute
- flush_fetch  out  1  squash fetch output
- flush_decode  out  1  squash decode output
- flush_execute  out  1  squash execute output
- sb_count  out  $clog2(DEPTH+1)  scoreboard occupancy
- sb_error  out  1  sticky protocol-error flag

Behaviour:
- Reset (asynchronous, active-high): queue empty, sb_count=0, FSM=RUN, flush counter=0, sb_error=0. All stall and flush outputs read 0 while reset is held. Reset in the middle of a flush drops the flush immediately.
- Scoreboard:
  - Circular FIFO of DEPTH entries. Each entry is {rd_addr}. Only instructions with dec_rd_wr=1 and rd≠x0 get an entry.
  - Every issue also pushes a parallel 1-bit "has_rd" tag, so retire ordering stays aligned. sb_count counts all in-flight instructions, including those without an entry.
- Hazard (combinational):
  - haz = dec_valid && ((dec_rs1_used && rs1≠0 && match(rs1)) || (dec_rs2_used && rs2≠0 && match(rs2))).
  - match() compares against every valid entry with has_rd=1.
  - An entry retiring this same cycle still counts as pending, because the regfile write becomes visible only after the edge.
- full = (sb_count==DEPTH) && !wb_valid. A retire in the same cycle frees a slot.
- stall_decode = stall_fetch = (haz || (dec_valid && full)) && state==RUN.
- issue = dec_valid && !stall_decode && state==RUN && !ex_redirect && !wb_exception. On issue, push at the clock edge.
- Retire:
  - On wb_valid, pop the head.
  - If the head has_rd differs from wb_rd_wr, or its rd differs from wb_rd_addr, set sb_error=1 (sticky until reset). The pop happens anyway.
  - wb_valid with an empty queue: no pop, set sb_error=1.
- Simultaneous push and pop: sb_count is unchanged and both pointers advance. Pointers wrap modulo DEPTH.
- FSM states:
  - RUN: flush outputs are 0.
    - wb_exception → go to FLUSH_ALL, load counter=FLUSH_CYCLES. This has priority over ex_redirect.
    - Else ex_redirect → go to FLUSH_FRONT, load counter.
  - FLUSH_FRONT: flush_fetch=flush_decode=1, stalls=0. Counter decrements each cycle; at 1, return to RUN. Retires continue. A wb_exception arriving here moves to FLUSH_ALL and reloads the counter.
  - FLUSH_ALL: flush_fetch=flush_decode=flush_execute=1. On the entry edge the whole queue is cleared (sb_count=0) and the same-cycle wb_valid is ignored. Counter behaves as in FLUSH_FRONT. wb_valid while in FLUSH_ALL: ignored, no error.
- Flush latency: the flush outputs are registered and assert in the cycle after the triggering input. The same-cycle issue is suppressed combinationally via the issue term above.
- No combinational path from stall outputs to any input.

Decomposition:
- def_params.v gets:
  - FSM state encodings `HC_RUN, `HC_FLUSH_FRONT, `HC_FLUSH_ALL.
  - Default `HC_DEPTH.
- One sub-module, inflight_queue: FIFO of {has_rd, rd}, plus parallel match outputs for two lookup addresses, count, clear and error detection. hazard_ctrl holds the FSM, counter and output logic.

Test Plan:
- Issue ADDI x5 (rd_wr=1); next cycle decode with rs1=x5 → stall_fetch=stall_decode=1 until wb_valid with rd=x5 retires; stall drops the cycle after; sb_count 1→0.
- Issue to x1,x2,x3,x4 with DEPTH=4 and no retire → sb_count=4; 5th dec_valid with no hazard → stall=1. Assert wb_valid in the same cycle → no stall, issue accepted, sb_count stays 4.
- ex_redirect pulse with dec_valid=1 → that instruction is not pushed; next cycle flush_fetch=flush_decode=1 and flush_execute=0 for exactly FLUSH_CYCLES cycles. Older entries retire normally with sb_error=0.
- wb_exception with sb_count=3 → next cycle sb_count=0, all three flushes=1. Same-cycle ex_redirect has no added effect.
- wb_valid with wb_rd_addr=x7 while head rd=x6 → sb_error=1 and stays 1. wb_valid with empty queue → sb_error=1 and sb_count stays 0.
- Source rs1=x0 with a pending x0 write attempt (rd_wr=1, rd=0) → no entry pushed, no stall. Assert reset mid-FLUSH_ALL → all outputs 0 immediately.
